regfile_write_scheduler: RTL

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

---
 rtl/regfile_write_scheduler.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Register-file write port arbiter: clears the file after reset, then serves
// the ALU and load writeback requesters round-robin at one write per cycle.
module regfile_write_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int REG_FILE_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0Valid,
  input  logic [REG_NUM_WIDTH-1:0] req0Num,
  input  logic [DATA_WIDTH-1:0]    req0Data,
  output logic                     req0Ready,
  input  logic                     req1Valid,
  input  logic [REG_NUM_WIDTH-1:0] req1Num,
  input  logic [DATA_WIDTH-1:0]    req1Data,
  output logic                     req1Ready,
  output logic                     wrEnable,
  output logic [REG_NUM_WIDTH-1:0] wrNum,
  output logic [DATA_WIDTH-1:0]    wrData,
  output logic                     initDone,
  output logic [15:0]              conflictCount
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [REG_NUM_WIDTH-1:0] LAST_IDX = REG_NUM_WIDTH'(REG_FILE_SIZE - 1);

  state_t                   state, stateNext;
  logic [REG_NUM_WIDTH-1:0] clearIdx;
  logic                     prio;
  logic                     bothValid;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= stateNext;
  end

  // prio names the requester that wins when both are valid
  always_comb begin
    stateNext = state;
    req0Ready = 1'b0;
    req1Ready = 1'b0;
    case (state)
      INIT: begin
        if (clearIdx == LAST_IDX) stateNext = RUN;
      end
      RUN: begin
        req0Ready = req0Valid & (~req1Valid | ~prio);
        req1Ready = req1Valid & (~req0Valid | prio);
      end
      default: stateNext = INIT;
    endcase
  end

  assign initDone  = (state == RUN);
  assign bothValid = req0Valid & req1Valid;

  // Registered write port; clear writes in INIT, granted writes in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clearIdx      <= '0;
      prio          <= 1'b0;
      wrEnable      <= 1'b0;
      wrNum         <= '0;
      wrData        <= '0;
      conflictCount <= 16'd0;
    end else if (state == INIT) begin
      wrEnable <= 1'b1;
      wrNum    <= clearIdx;
      wrData   <= '0;
      clearIdx <= clearIdx + 1'b1;
    end else begin
      if (bothValid) conflictCount <= satInc(conflictCount);
      if (req0Ready) begin
        wrEnable <= 1'b1;
        wrNum    <= req0Num;
        wrData   <= req0Data;
        prio     <= 1'b1;
      end else if (req1Ready) begin
        wrEnable <= 1'b1;
        wrNum    <= req1Num;
        wrData   <= req1Data;
        prio     <= 1'b0;
      end else begin
        wrEnable <= 1'b0;
      end
    end
  end

endmodule
